// File: rtl/conv_in_packer.sv
// Serial-to-parallel input stage for the 1-D binary convolution core.
// Packs a bit stream LSB-first into a zero-padded vector, latches the kernel and holds both behind a valid/ready handshake.
module conv_in_packer #(
  parameter int IN_W  = 255,
  parameter int KER_W = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_bit,
  input  logic             s_last,
  input  logic             k_load,
  input  logic [KER_W-1:0] k_data,
  output logic [IN_W-1:0]  in_vec,
  output logic [KER_W-1:0] ker_vec,
  output logic [LEN_W-1:0] m_len,
  output logic             m_trunc,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(IN_W - 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(IN_W);

  state_t             state_reg;
  logic [LEN_W-1:0]   cnt_reg;
  logic [IN_W-1:0]    in_vec_reg;
  logic [KER_W-1:0]   ker_vec_reg;
  logic [LEN_W-1:0]   m_len_reg;
  logic               m_trunc_reg;
  logic               m_valid_reg;
  logic               s_ready_reg;

  logic               accept;
  logic               fill_wr;
  logic               frame_clr;

  // s_ready_reg is low in HOLD and in the first cycle out of reset, so it alone gates acceptance.
  assign accept    = s_valid & s_ready_reg;
  assign fill_wr   = accept && (state_reg == FILL);
  assign frame_clr = (state_reg == HOLD) && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FILL;
      cnt_reg     <= '0;
      m_len_reg   <= '0;
      m_trunc_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      s_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          s_ready_reg <= 1'b1;
          if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (s_last) begin
              m_len_reg   <= cnt_reg + 1'b1;
              m_trunc_reg <= 1'b0;
              m_valid_reg <= 1'b1;
              s_ready_reg <= 1'b0;
              state_reg   <= HOLD;
            end else if (cnt_reg == LAST_IDX) begin
              m_len_reg   <= FULL_LEN;
              m_trunc_reg <= 1'b1;
              m_valid_reg <= 1'b1;
              s_ready_reg <= 1'b0;
              state_reg   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            cnt_reg     <= '0;
            m_len_reg   <= '0;
            m_trunc_reg <= 1'b0;
            m_valid_reg <= 1'b0;
            s_ready_reg <= 1'b1;
            // A truncated frame still has a tail upstream that must be swallowed.
            state_reg   <= m_trunc_reg ? DROP : FILL;
          end
        end
        DROP: begin
          s_ready_reg <= 1'b1;
          if (accept && s_last) begin
            state_reg <= FILL;
          end
        end
        default: begin
          state_reg   <= FILL;
          s_ready_reg <= 1'b0;
          m_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Kernel is frozen while a frame is held so the core sees a consistent pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ker_vec_reg <= '0;
    end else if (k_load && (state_reg != HOLD)) begin
      ker_vec_reg <= k_data;
    end
  end

  for (genvar gi = 0; gi < IN_W; gi++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_vec_reg[gi] <= 1'b0;
      end else if (frame_clr) begin
        in_vec_reg[gi] <= 1'b0;
      end else if (fill_wr && (cnt_reg == LEN_W'(gi))) begin
        in_vec_reg[gi] <= s_bit;
      end
    end
  end

  assign in_vec  = in_vec_reg;
  assign ker_vec = ker_vec_reg;
  assign m_len   = m_len_reg;
  assign m_trunc = m_trunc_reg;
  assign m_valid = m_valid_reg;
  assign s_ready = s_ready_reg;

endmodule

// File: tb/tb_conv_in_packer.sv
// Randomized self-checking bench for conv_in_packer; expectations come from a frame-level model
// (first min(len, IN_W) bits of each source frame, truncation when the source frame is longer).
module tb_conv_in_packer;

  localparam int IN_W  = 255;
  localparam int KER_W = 3;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             s_bit = 1'b0;
  logic             s_last = 1'b0;
  logic             k_load = 1'b0;
  logic [KER_W-1:0] k_data = '0;
  logic [IN_W-1:0]  in_vec;
  logic [KER_W-1:0] ker_vec;
  logic [LEN_W-1:0] m_len;
  logic             m_trunc;
  logic             m_valid;
  logic             m_ready = 1'b0;

  conv_in_packer #(.IN_W(IN_W), .KER_W(KER_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit), .s_last(s_last),
    .k_load(k_load), .k_data(k_data),
    .in_vec(in_vec), .ker_vec(ker_vec), .m_len(m_len), .m_trunc(m_trunc),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: the source frame being sent and its expected packed view.
  bit               frame_q[$];
  logic [KER_W-1:0] exp_ker = '0;
  logic [IN_W-1:0]  exp_vec;
  int               exp_len;
  bit               exp_trunc;

  function automatic void build_model();
    int n;
    n = (frame_q.size() > IN_W) ? IN_W : frame_q.size();
    exp_vec = '0;
    for (int i = 0; i < n; i++) exp_vec[i] = frame_q[i];
    exp_len   = n;
    exp_trunc = (frame_q.size() > IN_W);
  endfunction

  // Offers frame_q[lo..hi-1] on the stream; returns just after the edge that accepts the final bit.
  task automatic drive_bits(input int lo, input int hi, input bit gaps);
    int idx;
    int budget;
    bit acc;
    idx = lo;
    budget = 0;
    while (idx < hi) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_bit   = frame_q[idx];
        s_last  = (idx == frame_q.size() - 1);
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) idx++;
      budget++;
      if (budget > 2000) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: got %0d of %0d bits accepted, want all", idx - lo, hi - lo);
        break;
      end
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called right after the final bit is accepted: the frame must be presented in the very next cycle.
  task automatic check_frame();
    build_model();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_m_valid: got %b want 1", m_valid);
    end
    checks++;
    if (in_vec !== exp_vec) begin
      errors++;
      $display("FAIL in_vec: got %h want %h", in_vec, exp_vec);
    end
    checks++;
    if (m_len !== LEN_W'(exp_len)) begin
      errors++;
      $display("FAIL m_len: got %0d want %0d", m_len, exp_len);
    end
    checks++;
    if (m_trunc !== exp_trunc) begin
      errors++;
      $display("FAIL m_trunc: got %b want %b", m_trunc, exp_trunc);
    end
    checks++;
    if (ker_vec !== exp_ker) begin
      errors++;
      $display("FAIL ker_vec: got %b want %b", ker_vec, exp_ker);
    end
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_s_ready: got %b want 0", s_ready);
    end
    $display("frame src_len=%0d len=%0d trunc=%0d ker=%b", frame_q.size(), exp_len, exp_trunc, exp_ker);
  endtask

  // Holds off m_ready for hold_cycles (optionally poking k_load), handshakes, then drains any tail.
  task automatic release_frame(input int hold_cycles, input bit kload, input bit gaps);
    for (int c = 0; c < hold_cycles; c++) begin
      k_load  = kload;
      k_data  = 3'b011;
      m_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (!(m_valid === 1'b1 && s_ready === 1'b0 && in_vec === exp_vec &&
            m_len === LEN_W'(exp_len) && m_trunc === exp_trunc && ker_vec === exp_ker)) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got v=%b r=%b len=%0d tr=%b ker=%b vec=%h want v=1 r=0 len=%0d tr=%b ker=%b vec=%h",
                 c, m_valid, s_ready, m_len, m_trunc, ker_vec, in_vec, exp_len, exp_trunc, exp_ker, exp_vec);
      end
    end
    k_load  = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
    checks++;
    if (in_vec !== '0 || m_len !== '0 || m_trunc !== 1'b0) begin
      errors++;
      $display("FAIL cleared: got vec=%h len=%0d trunc=%b want 0 0 0", in_vec, m_len, m_trunc);
    end
    if (exp_trunc) drive_bits(IN_W, frame_q.size(), gaps);
  endtask

  task automatic load_kernel(input logic [KER_W-1:0] k);
    @(negedge clk);
    k_load = 1'b1;
    k_data = k;
    @(negedge clk);
    k_load = 1'b0;
    exp_ker = k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_vec !== '0 || ker_vec !== '0 || m_len !== '0 || m_trunc !== 1'b0 ||
        m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got vec=%h ker=%b len=%0d tr=%b v=%b r=%b want all 0",
               in_vec, ker_vec, m_len, m_trunc, m_valid, s_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_s_ready: got %b want 1", s_ready);
    end
  endtask

  task automatic test_short_frame();
    load_kernel(3'b101);
    frame_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    drive_bits(0, frame_q.size(), 1'b0);
    check_frame();
    checks++;
    if (in_vec !== IN_W'(13) || ker_vec !== 3'b101) begin
      errors++;
      $display("FAIL short_const: got vec=%h ker=%b want vec=d ker=101", in_vec, ker_vec);
    end
  endtask

  task automatic test_backpressure();
    release_frame(10, 1'b1, 1'b0);
  endtask

  task automatic test_exact_fill();
    frame_q.delete();
    for (int i = 0; i < IN_W; i++) frame_q.push_back(1'b1);
    drive_bits(0, IN_W, 1'b0);
    check_frame();
    checks++;
    if (in_vec !== {IN_W{1'b1}} || m_trunc !== 1'b0) begin
      errors++;
      $display("FAIL exact_fill: got vec=%h trunc=%b want all ones, trunc 0", in_vec, m_trunc);
    end
    release_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    frame_q.delete();
    for (int i = 0; i < 260; i++) frame_q.push_back(1'($urandom));
    drive_bits(0, IN_W, 1'b0);
    check_frame();
    release_frame(0, 1'b0, 1'b0);
    frame_q = '{1'b1, 1'b1};
    drive_bits(0, 2, 1'b0);
    check_frame();
    checks++;
    if (in_vec !== IN_W'(3) || m_len !== LEN_W'(2)) begin
      errors++;
      $display("FAIL after_drop: got vec=%h len=%0d want 3 2", in_vec, m_len);
    end
    release_frame(1, 1'b0, 1'b0);
  endtask

  task automatic test_gapped();
    frame_q = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive_bits(0, 4, 1'b1);
    check_frame();
    checks++;
    if (in_vec !== IN_W'(11) || m_len !== LEN_W'(4)) begin
      errors++;
      $display("FAIL gapped: got vec=%h len=%0d want b 4", in_vec, m_len);
    end
    release_frame(2, 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) load_kernel(KER_W'($urandom));
      len = (f % 3 == 0) ? $urandom_range(240, 300) : $urandom_range(1, 40);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(1'($urandom));
      drive_bits(0, (len > IN_W) ? IN_W : len, 1'($urandom));
      check_frame();
      release_frame($urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drive_bits(0, 3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (in_vec !== '0 || ker_vec !== '0 || m_len !== '0 || m_trunc !== 1'b0 ||
        m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got vec=%h ker=%b len=%0d tr=%b v=%b r=%b want all 0",
               in_vec, ker_vec, m_len, m_trunc, m_valid, s_ready);
    end
    exp_ker = '0;
    @(negedge clk);
    rst = 1'b0;
    frame_q = '{1'b1};
    drive_bits(0, 1, 1'b0);
    check_frame();
    checks++;
    if (in_vec !== IN_W'(1) || m_len !== LEN_W'(1)) begin
      errors++;
      $display("FAIL post_reset_frame: got vec=%h len=%0d want 1 1", in_vec, m_len);
    end
    release_frame(0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_backpressure();
    test_exact_fill();
    test_overflow();
    test_gapped();
    test_random_frames();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
